// File: rtl/jpeg_idct_pkg.sv
// Shared constants, reader-state encoding and address helpers for the
// in-place 8x8 IDCT transpose buffer.
package jpeg_idct_pkg;

  localparam int BLK_SIZE = 64;
  localparam int IDX_W    = 6;
  localparam int CNT_W    = IDX_W + 1;
  localparam int DATA_W   = 16;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_RUN  = 1'b1
  } rd_state_e;

  // Swap row and column fields of a row-major 8x8 index.
  function automatic logic [IDX_W-1:0] tpose_idx(input logic [IDX_W-1:0] k);
    return {k[2:0], k[5:3]};
  endfunction

  function automatic logic [IDX_W-1:0] wr_addr_map(input logic mode,
                                                   input logic [IDX_W-1:0] k);
    return mode ? tpose_idx(k) : k;
  endfunction

  function automatic logic [IDX_W-1:0] rd_addr_map(input logic mode,
                                                   input logic [IDX_W-1:0] k);
    return mode ? k : tpose_idx(k);
  endfunction

endpackage

// File: rtl/jpeg_idct_ram_dp.sv
// 64x16 dual-port RAM: port 1 registers its address (held unless en1_i) and
// reads asynchronously from it. Both write ports sample on clk0_i.
module jpeg_idct_ram_dp
  import jpeg_idct_pkg::*;
(
  input  logic              clk0_i,
  input  logic              rst0_i,
  input  logic              wr0_i,
  input  logic [IDX_W-1:0]  addr0_i,
  input  logic [DATA_W-1:0] data0_i,
  input  logic              clk1_i,
  input  logic              rst1_i,
  input  logic              en1_i,
  input  logic              wr1_i,
  input  logic [IDX_W-1:0]  addr1_i,
  input  logic [DATA_W-1:0] data1_i,
  output logic [DATA_W-1:0] data1_o
);

  logic [DATA_W-1:0] r_mem [BLK_SIZE];
  logic [IDX_W-1:0]  r_addr1;

  // Contents are never reset; writes are simply suppressed while in reset.
  always_ff @(posedge clk0_i) begin
    if (!rst1_i && wr1_i && en1_i) begin
      r_mem[addr1_i] <= data1_i;
    end
    if (!rst0_i && wr0_i) begin
      r_mem[addr0_i] <= data0_i;
    end
  end

  always_ff @(posedge clk1_i or posedge rst1_i) begin
    if (rst1_i) begin
      r_addr1 <= '0;
    end else if (en1_i) begin
      r_addr1 <= addr1_i;
    end
  end

  assign data1_o = r_mem[r_addr1];

endmodule

// File: rtl/jpeg_idct_transpose_ctrl.sv
// Transpose buffer between IDCT row and column passes: row-major in,
// column-major out, one block transposed in place by alternating address modes.
module jpeg_idct_transpose_ctrl
  import jpeg_idct_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inp_valid_i,
  input  logic [15:0] inp_data_i,
  output logic        inp_accept_o,
  output logic        outp_valid_o,
  output logic [15:0] outp_data_o,
  output logic        outp_last_o,
  input  logic        outp_ready_i,
  output logic        busy_o
);

  // Output handshake: a coefficient transfers on a cycle where outp_valid_o
  // and outp_ready_i are both high; outp_data_o/outp_last_o hold while stalled.

  logic [IDX_W-1:0] r_wr_idx;
  logic             r_wr_mode;
  logic             r_full;
  rd_state_e        r_rd_state;
  rd_state_e        w_rd_state_nxt;
  logic [CNT_W-1:0] r_rd_iss_cnt;
  logic [CNT_W-1:0] r_rd_acc_cnt;
  logic [CNT_W-1:0] w_iss_cnt_nxt;
  logic [CNT_W-1:0] w_acc_cnt_nxt;
  logic [CNT_W-1:0] w_iss_base;
  logic             r_rd_mode;
  logic             w_rd_mode_nxt;
  logic             w_cur_mode;
  logic             r_outp_valid;
  logic             w_outp_valid_nxt;
  logic             w_wr_ok;
  logic             w_wr_fire;
  logic             w_wr_last;
  logic             w_rd_issue;
  logic             w_out_fire;
  logic             w_out_last_fire;
  logic [IDX_W-1:0] w_wr_addr;
  logic [IDX_W-1:0] w_rd_addr;

  // Writer gating looks only at registered state, never at inp_valid_i.
  assign w_wr_ok      = !r_full &&
                        ((r_rd_state == RD_IDLE) || ({1'b0, r_wr_idx} < r_rd_acc_cnt));
  assign inp_accept_o = w_wr_ok & rst_i;
  assign w_wr_fire    = inp_valid_i & inp_accept_o;
  assign w_wr_last    = w_wr_fire && (r_wr_idx == IDX_W'(BLK_SIZE - 1));
  assign w_wr_addr    = wr_addr_map(r_wr_mode, r_wr_idx);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_idx  <= '0;
      r_wr_mode <= 1'b0;
    end else if (w_wr_fire) begin
      r_wr_idx <= r_wr_idx + IDX_W'(1);
      if (w_wr_last) begin
        r_wr_mode <= ~r_wr_mode;
      end
    end
  end

  // A newly completed block takes precedence over the release of the old one.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_full <= 1'b0;
    end else if (w_wr_last) begin
      r_full <= 1'b1;
    end else if (w_out_last_fire) begin
      r_full <= 1'b0;
    end
  end

  // Reader: the first read issues in the start cycle itself, using the mode of
  // the block just completed (the writer has already toggled past it).
  always_comb begin
    w_rd_state_nxt   = r_rd_state;
    w_rd_mode_nxt    = r_rd_mode;
    w_cur_mode       = r_rd_mode;
    w_iss_base       = r_rd_iss_cnt;
    w_acc_cnt_nxt    = r_rd_acc_cnt;
    w_rd_issue       = 1'b0;
    w_out_fire       = r_outp_valid && outp_ready_i;
    w_out_last_fire  = 1'b0;
    case (r_rd_state)
      RD_IDLE: begin
        if (r_full) begin
          w_rd_state_nxt = RD_RUN;
          w_rd_mode_nxt  = ~r_wr_mode;
          w_cur_mode     = ~r_wr_mode;
          w_iss_base     = '0;
          w_acc_cnt_nxt  = '0;
          w_rd_issue     = !r_outp_valid || outp_ready_i;
        end
      end
      RD_RUN: begin
        w_rd_issue = (r_rd_iss_cnt < CNT_W'(BLK_SIZE)) &&
                     (!r_outp_valid || outp_ready_i);
        if (w_out_fire) begin
          w_acc_cnt_nxt = r_rd_acc_cnt + CNT_W'(1);
          if (r_rd_acc_cnt == CNT_W'(BLK_SIZE - 1)) begin
            w_out_last_fire = 1'b1;
            w_rd_state_nxt  = RD_IDLE;
          end
        end
      end
      default: begin
        w_rd_state_nxt = RD_IDLE;
      end
    endcase
    w_iss_cnt_nxt    = w_rd_issue ? (w_iss_base + CNT_W'(1)) : w_iss_base;
    w_outp_valid_nxt = w_rd_issue ? 1'b1 : (w_out_fire ? 1'b0 : r_outp_valid);
  end

  assign w_rd_addr = rd_addr_map(w_cur_mode, w_iss_base[IDX_W-1:0]);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rd_state   <= RD_IDLE;
      r_rd_mode    <= 1'b0;
      r_rd_iss_cnt <= '0;
      r_rd_acc_cnt <= '0;
      r_outp_valid <= 1'b0;
    end else begin
      r_rd_state   <= w_rd_state_nxt;
      r_rd_mode    <= w_rd_mode_nxt;
      r_rd_iss_cnt <= w_iss_cnt_nxt;
      r_rd_acc_cnt <= w_acc_cnt_nxt;
      r_outp_valid <= w_outp_valid_nxt;
    end
  end

  jpeg_idct_ram_dp u_ram (
    .clk0_i  (clk_i),
    .rst0_i  (~rst_i),
    .wr0_i   (w_wr_fire),
    .addr0_i (w_wr_addr),
    .data0_i (inp_data_i),
    .clk1_i  (clk_i),
    .rst1_i  (~rst_i),
    .en1_i   (w_rd_issue),
    .wr1_i   (1'b0),
    .addr1_i (w_rd_addr),
    .data1_i ({DATA_W{1'b0}}),
    .data1_o (outp_data_o)
  );

  assign outp_valid_o = r_outp_valid;
  assign outp_last_o  = r_outp_valid && (r_rd_acc_cnt == CNT_W'(BLK_SIZE - 1));
  assign busy_o       = (r_wr_idx != '0) || r_full || (r_rd_state == RD_RUN);

endmodule

// File: tb/tb_jpeg_idct_transpose_ctrl.sv
// Bench for jpeg_idct_transpose_ctrl: collects accepted inputs into 8x8
// blocks and expects each block back column by column.
module tb_jpeg_idct_transpose_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        inp_valid_i = 1'b0;
  logic [15:0] inp_data_i = '0;
  logic        outp_ready_i = 1'b0;
  logic        inp_accept_o;
  logic        outp_valid_o;
  logic [15:0] outp_data_o;
  logic        outp_last_o;
  logic        busy_o;

  always #5 clk_i = ~clk_i;

  jpeg_idct_transpose_ctrl dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .inp_valid_i  (inp_valid_i),
    .inp_data_i   (inp_data_i),
    .inp_accept_o (inp_accept_o),
    .outp_valid_o (outp_valid_o),
    .outp_data_o  (outp_data_o),
    .outp_last_o  (outp_last_o),
    .outp_ready_i (outp_ready_i),
    .busy_o       (busy_o)
  );

  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          out_k = 0;
  int          last_in_cyc = 0;
  int          first_out_cyc = 0;
  bit          rand_done = 1'b0;
  logic [15:0] in_blk[$];
  logic [16:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model and scoreboard. Output k of a block is the input at
  // row (k mod 8), column (k div 8) of the row-major block.
  always @(negedge clk_i) begin
    logic [16:0] e;
    cyc++;
    if (!rst_i) begin
      in_blk.delete();
      exp_q.delete();
      out_k = 0;
    end else begin
      if (inp_valid_i && inp_accept_o) begin
        in_blk.push_back(inp_data_i);
        if (in_blk.size() == 64) begin
          last_in_cyc = cyc;
          for (int k = 0; k < 64; k++) begin
            exp_q.push_back({(k == 63), in_blk[(k % 8) * 8 + (k / 8)]});
          end
          in_blk.delete();
        end
      end
      if (outp_valid_o && outp_ready_i) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_output: got data %0d with nothing expected", outp_data_o);
        end else begin
          e = exp_q.pop_front();
          check("out_data", outp_data_o, e[15:0]);
          check("out_last", outp_last_o, e[16]);
        end
        if (out_k == 0) first_out_cyc = cyc;
        out_k = (out_k == 63) ? 0 : out_k + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_word(input logic [15:0] d, input int valid_pct);
    int waited = 0;
    while (valid_pct < 100 && $urandom_range(99, 0) >= valid_pct) begin
      inp_valid_i = 1'b0;
      tick();
    end
    inp_valid_i = 1'b1;
    inp_data_i  = d;
    @(negedge clk_i);
    while (!inp_accept_o && waited < 400) begin
      @(negedge clk_i);
      waited++;
    end
    if (waited >= 400) check("send_timeout", waited, 0);
    tick();
    inp_valid_i = 1'b0;
  endtask

  task automatic send_block(input int base, input bit rnd, input int valid_pct);
    for (int i = 0; i < 64; i++) begin
      send_word(rnd ? 16'($urandom) : 16'(base + i), valid_pct);
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || outp_valid_o) && g < 3000) begin
      @(negedge clk_i);
      g++;
    end
    if (g >= 3000) check("drain_timeout", g, 0);
    tick();
  endtask

  task automatic stall_at_17();
    int stalls = 0;
    int guard = 0;
    outp_ready_i = 1'b1;
    while (stalls < 10 && guard < 3000) begin
      tick();
      guard++;
      if (out_k == 17) begin
        outp_ready_i = 1'b0;
        stalls++;
        @(negedge clk_i);
        check("stall_valid", outp_valid_o, 1);
        if (exp_q.size() > 0) check("stall_data_hold", outp_data_o, exp_q[0][15:0]);
        if (stalls == 10) begin
          check("stall_accept_low", inp_accept_o, 0);
          check("stall_busy", busy_o, 1);
        end
      end
    end
    if (stalls < 10) check("stall_reached", stalls, 10);
    outp_ready_i = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    // Reset behaviour, with valid high so accept gating is exercised.
    rst_i = 1'b0;
    inp_valid_i = 1'b1;
    @(negedge clk_i);
    check("rst_accept", inp_accept_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_outp_valid", outp_valid_o, 0);
    tick();
    tick();
    inp_valid_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("idle_accept_without_valid", inp_accept_o, 1);
    check("idle_busy", busy_o, 0);
    check("idle_outp_valid", outp_valid_o, 0);
    tick();

    // Sequential block, continuous ready, first-output latency.
    outp_ready_i = 1'b1;
    send_block(0, 1'b0, 100);
    drain();
    check("first_out_latency", first_out_cyc - last_in_cyc, 2);

    // Three consecutive blocks through alternating modes.
    send_block(0, 1'b0, 100);
    send_block(100, 1'b0, 100);
    send_block(200, 1'b0, 100);
    drain();

    // Ten-cycle output stall at output 17 while the next block is offered.
    fork
      begin
        send_block(0, 1'b1, 100);
        send_block(0, 1'b1, 100);
      end
      stall_at_17();
    join
    drain();

    // Downstream never ready: a second block must not get in.
    outp_ready_i = 1'b0;
    send_block(0, 1'b1, 100);
    tick();
    tick();
    @(negedge clk_i);
    check("full_outp_valid", outp_valid_o, 1);
    if (exp_q.size() > 0) check("full_first_data", outp_data_o, exp_q[0][15:0]);
    tick();
    acc = 0;
    inp_valid_i = 1'b1;
    inp_data_i = 16'($urandom);
    repeat (40) begin
      @(negedge clk_i);
      if (inp_accept_o) acc++;
      tick();
    end
    inp_valid_i = 1'b0;
    check("blocked_accepts", acc, 0);
    @(negedge clk_i);
    check("blocked_busy", busy_o, 1);
    if (exp_q.size() > 0) check("blocked_data_hold", outp_data_o, exp_q[0][15:0]);
    tick();
    outp_ready_i = 1'b1;
    send_block(0, 1'b1, 100);
    drain();

    // Reset in the middle of a block.
    for (int i = 0; i < 30; i++) send_word(16'(1000 + i), 100);
    rst_i = 1'b0;
    inp_valid_i = 1'b1;
    @(negedge clk_i);
    check("midrst_accept", inp_accept_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_outp_valid", outp_valid_o, 0);
    tick();
    inp_valid_i = 1'b0;
    rst_i = 1'b1;
    tick();
    @(negedge clk_i);
    check("postrst_busy", busy_o, 0);
    check("postrst_outp_valid", outp_valid_o, 0);
    tick();
    send_block(0, 1'b0, 100);
    drain();
    check("postrst_latency", first_out_cyc - last_in_cyc, 2);

    // Random valid/ready over 20 blocks.
    fork
      begin
        for (int b = 0; b < 20; b++) send_block(0, 1'b1, 70);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          outp_ready_i = ($urandom_range(99, 0) < 60);
          tick();
        end
        outp_ready_i = 1'b1;
      end
    join
    drain();
    check("leftover_expected", exp_q.size(), 0);
    check("final_busy", busy_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jpeg_idct_transpose_ctrl.md
JPEG_IDCT_TRANSPOSE_CTRL -- requirements
Module: jpeg_idct_transpose_ctrl

Interface
REQ-001 SHALL have no parameters; block size is fixed at 8x8 (64 coefficients, 16 bits each).
REQ-002 SHALL have port: clk_i  input  1  sole clock; both RAM ports are clocked by it.
REQ-003 SHALL have port: rst_i  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: inp_valid_i  input  1  row-pass result valid.
REQ-005 SHALL have port: inp_data_i  input  16  row-pass result, arriving in row-major order.
REQ-006 SHALL have port: inp_accept_o  output  1  input accepted this cycle (when also valid).
REQ-007 SHALL have port: outp_valid_o  output  1  transposed coefficient valid.
REQ-008 SHALL have port: outp_data_o  output  16  transposed coefficient, in column-major order.
REQ-009 SHALL have port: outp_last_o  output  1  qualifies the 64th output of a block.
REQ-010 SHALL have port: outp_ready_i  input  1  downstream ready.
REQ-011 SHALL have port: busy_o  output  1  high while a block is partly written, stored or partly read.

Function
REQ-012 SHALL store one 64x16 block in a single dual-port RAM: port 0 write-only (writer), port 1 read-only (reader).
REQ-013 SHALL transpose in place using alternating address modes; T(k) = {k[2:0],k[5:3]}.
  - Mode 0: write address = k, read address = T(k).
  - Mode 1: write address = T(k), read address = k.
REQ-014 SHALL toggle the writer mode on each completed block; the reader SHALL latch that mode when it starts the block.
REQ-015 SHALL make the k-th output of every block equal input element T(k), in both modes.
REQ-016 SHALL gate the writer (6-bit index wr_idx):
  - Accept when full_q=0 and either no read is in progress or wr_idx < rd_acc_cnt (outputs consumed).
  - Never accept when full_q=1.
REQ-017 SHALL assert inp_accept_o without depending combinationally on inp_valid_i.
REQ-018 SHALL write on accept in the same cycle, then increment wr_idx (wrap 63->0).
REQ-019 SHALL set full_q in the cycle after index 63 is written.
REQ-020 SHALL give the reader two states:
  - RD_IDLE -> RD_RUN when full_q=1; this clears rd_iss_cnt and rd_acc_cnt.
  - RD_RUN -> RD_IDLE on acceptance of the 64th output; this also clears full_q.
REQ-021 SHALL issue a read when in RD_RUN, rd_iss_cnt<64 and (!outp_valid_o or outp_ready_i).
REQ-022 SHALL assert outp_valid_o the cycle after an issue, with outp_data_o driven directly by RAM port-1 data (1-cycle latency).
REQ-023 SHALL hold the port-1 address at the last issued address when not issuing, so outp_data_o stays stable under backpressure.
REQ-024 SHALL clear outp_valid_o on acceptance with no new issue; back-to-back accepts SHALL sustain 1 output per cycle.
REQ-025 SHALL use rd_acc_cnt (not rd_iss_cnt) for writer gating, so an issued but unaccepted address is never overwritten.
REQ-026 SHALL let full_q clearing (last accept) and writer restart coincide; the writer SHALL accept index 0 in the cycle after the last accept at the latest.
REQ-027 SHALL assert busy_o when wr_idx!=0 or full_q or in RD_RUN.

Reset
REQ-028 SHALL, on rst_i low, asynchronously clear: wr_idx, wr_mode, full_q, reader state (RD_IDLE), rd_iss_cnt, rd_acc_cnt, rd_mode, port-1 address register and outp_valid_o.
REQ-029 SHALL drive inp_accept_o=0 and busy_o=0 during reset; RAM contents SHALL NOT be reset.
REQ-030 SHALL discard any partial block when reset is asserted mid-operation; the first post-reset block SHALL use mode 0.

Structure
REQ-031 SHALL place the block-size constant (64), the index width (6) and the reader-state encoding in shared package jpeg_idct_pkg.
REQ-032 SHALL instantiate jpeg_idct_ram_dp as its only sub-module, with clk0_i and clk1_i tied to clk_i, rst0_i and rst1_i tied to ~rst_i, and wr1_i and data1_i tied to 0.

Verification
REQ-033 SHALL cover: inputs 0..63 streamed with outp_ready_i=1 -> outputs 0,8,16,...,56,1,9,...,63; outp_last_o on value 63; first output 2 cycles after the last input.
REQ-034 SHALL cover: three consecutive blocks (base 0, 100, 200), ready=1 -> each block correctly transposed, exercising mode 0, 1, 0; writer overlaps the reader.
REQ-035 SHALL cover: outp_ready_i low for 10 cycles mid-block at output 17 -> outp_data_o held at 17's value and inp_accept_o stalls at wr_idx=rd_acc_cnt; no data loss.
REQ-036 SHALL cover: outp_ready_i=0 throughout after block 1 fills -> block 2 accepts 0 inputs while full_q=1 and the reader has consumed nothing; busy_o=1.
REQ-037 SHALL cover: rst_i low after 30 inputs -> outputs idle; a new block 0..63 then transposes correctly in mode 0.
REQ-038 SHALL cover: random inp_valid_i/outp_ready_i over 20 blocks -> scoreboard matches the transpose reference, with no overwrite of unaccepted data.
